// File: rtl/tristate_bus_pkg.sv
// Shared types for the harness-side tristate bus endpoint.
// Bus ownership states and default data width.
package tristate_bus_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    TURN,
    LISTEN
  } bus_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count and head-of-queue view.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tristate_bus_host.sv
// Harness end of a shared tristate bus: drives queued words while the
// DUT listens, captures while the DUT drives, one turnaround between.
module tristate_bus_host
  import tristate_bus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             dut_oe,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  input  logic             rx_ready,
  output logic             drive_en,
  output logic             contention,
  output logic             overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  bus_state_t       state;
  logic [CW-1:0]    tx_count;
  logic [CW-1:0]    rx_count;
  logic [WIDTH-1:0] tx_head;
  logic             tx_push;
  logic             tx_pop;
  logic             tx_empty;
  logic             tx_drain;
  logic             rx_push;
  logic             rx_pop;
  logic             rx_full;

  assign tx_empty = tx_count == '0;
  assign tx_ready = tx_count != FULL_CNT;
  assign tx_push  = tx_valid && tx_ready;
  assign rx_full  = rx_count == FULL_CNT;
  assign rx_valid = rx_count != '0;
  assign rx_pop   = rx_ready && rx_valid;

  // Gated by dut_oe directly so the host lets go in the very cycle the DUT takes over.
  assign drive_en = (state == DRIVE) && !dut_oe;
  assign tx_pop   = drive_en && !tx_empty;
  assign tx_drain = (tx_count == ONE_CNT) && !tx_push;
  assign rx_push  = dut_oe && ((state == IDLE) || (state == LISTEN));
  assign bus      = drive_en ? tx_head : {WIDTH{1'bz}};

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (tx_data),
    .count (tx_count),
    .head  (tx_head)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (bus),
    .count (rx_count),
    .head  (rx_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      contention <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (rx_push && rx_full && !rx_pop)
        overflow <= 1'b1;
      unique case (state)
        IDLE: begin
          if (dut_oe)
            state <= LISTEN;
          else if (!tx_empty)
            state <= DRIVE;
        end
        DRIVE: begin
          if (dut_oe) begin
            state      <= TURN;
            contention <= 1'b1;
          end else if (tx_drain) begin
            state <= IDLE;
          end
        end
        TURN: begin
          state <= dut_oe ? LISTEN : IDLE;
        end
        LISTEN: begin
          if (!dut_oe)
            state <= TURN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tristate_bus_host.sv
// Randomized and directed bench for tristate_bus_host against a
// queue-based model of bus ownership.
module tb_tristate_bus_host;

  localparam int W = 16;
  localparam int D = 4;

  localparam int OWN_NONE = 0;
  localparam int OWN_HOST = 1;
  localparam int OWN_GAP  = 2;
  localparam int OWN_DUT  = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         dut_oe;
  logic         tx_valid;
  logic [W-1:0] tx_data;
  logic         tx_ready;
  logic         rx_valid;
  logic [W-1:0] rx_data;
  logic         rx_ready;
  logic         drive_en;
  logic         contention;
  logic         overflow;
  logic [W-1:0] dut_word;
  wire  [W-1:0] bus;

  assign bus = dut_oe ? dut_word : {W{1'bz}};

  always #5 clk = ~clk;

  tristate_bus_host #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dut_oe     (dut_oe),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .drive_en   (drive_en),
    .contention (contention),
    .overflow   (overflow)
  );

  int n_chk = 0;
  int n_fail = 0;

  int           own;
  logic [W-1:0] txq[$];
  logic [W-1:0] rxq[$];
  logic         m_cont;
  logic         m_ovf;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model update for one rising edge, from the current inputs.
  task automatic model_edge();
    bit host_drv;
    bit cap;
    bit rpop;
    bit tpush;
    int tx_before;
    if (reset) begin
      txq.delete();
      rxq.delete();
      own    = OWN_NONE;
      m_cont = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      host_drv  = (own == OWN_HOST) && !dut_oe;
      cap       = dut_oe && (own == OWN_NONE || own == OWN_DUT);
      rpop      = rx_ready && (rxq.size() > 0);
      tpush     = tx_valid && (txq.size() < D);
      tx_before = txq.size();
      if (rpop)
        void'(rxq.pop_front());
      if (cap) begin
        if (rxq.size() < D)
          rxq.push_back(dut_word);
        else
          m_ovf = 1'b1;
      end
      if (host_drv)
        void'(txq.pop_front());
      if (tpush)
        txq.push_back(tx_data);
      case (own)
        OWN_NONE: begin
          if (dut_oe)
            own = OWN_DUT;
          else if (tx_before > 0)
            own = OWN_HOST;
        end
        OWN_HOST: begin
          if (dut_oe) begin
            own    = OWN_GAP;
            m_cont = 1'b1;
          end else if (txq.size() == 0) begin
            own = OWN_NONE;
          end
        end
        OWN_GAP: own = dut_oe ? OWN_DUT : OWN_NONE;
        default: if (!dut_oe) own = OWN_GAP;
      endcase
    end
  endtask

  task automatic check_comb();
    bit exp_drv;
    exp_drv = (own == OWN_HOST) && !dut_oe;
    check("drive_en", {31'b0, drive_en}, {31'b0, exp_drv});
    check("no_overlap", {31'b0, drive_en & dut_oe}, 32'd0);
    if (exp_drv && txq.size() > 0)
      check("bus_host", {16'b0, bus}, {16'b0, txq[0]});
    else if (dut_oe)
      check("bus_dut", {16'b0, bus}, {16'b0, dut_word});
  endtask

  task automatic check_regs();
    logic [W-1:0] exp_rx;
    exp_rx = (rxq.size() > 0) ? rxq[0] : '0;
    check("tx_ready", {31'b0, tx_ready}, {31'b0, txq.size() < D});
    check("rx_valid", {31'b0, rx_valid}, {31'b0, rxq.size() > 0});
    check("rx_data", {16'b0, rx_data}, {16'b0, exp_rx});
    check("contention", {31'b0, contention}, {31'b0, m_cont});
    check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
  endtask

  task automatic tick(input logic tv, input logic [W-1:0] td,
                      input logic oe, input logic rr,
                      input logic [W-1:0] dw, input logic rs);
    tx_valid = tv;
    tx_data  = td;
    dut_oe   = oe;
    rx_ready = rr;
    dut_word = dw;
    reset    = rs;
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic idle_ticks(input int n, input logic oe, input logic rr);
    for (int i = 0; i < n; i++)
      tick(1'b0, '0, oe, rr, 16'd13333, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    own      = OWN_NONE;
    m_cont   = 1'b0;
    m_ovf    = 1'b0;
    reset    = 1'b1;
    dut_oe   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    rx_ready = 1'b0;
    dut_word = '0;
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
    do_reset();
    check("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_rx_data", {16'b0, rx_data}, 32'd0);
    check("rst_drive_en", {31'b0, drive_en}, 32'd0);

    // DUT drives 13333 for three cycles
    idle_ticks(3, 1'b1, 1'b0);
    check("listen_rx_valid", {31'b0, rx_valid}, 32'd1);
    check("listen_rx_data", {16'b0, rx_data}, 32'd13333);
    idle_ticks(4, 1'b0, 1'b1);
    check("listen_drained", {31'b0, rx_valid}, 32'd0);
    check("listen_no_flags", {30'b0, contention, overflow}, 32'd0);

    // Back-to-back words 1, 2, 3
    for (int i = 1; i <= 3; i++)
      tick(1'b1, W'(i), 1'b0, 1'b1, '0, 1'b0);
    idle_ticks(5, 1'b0, 1'b1);

    // Contention: 5 driven, then DUT grabs the bus before 6
    tick(1'b1, 16'd5, 1'b0, 1'b1, '0, 1'b0);
    tick(1'b1, 16'd6, 1'b0, 1'b1, '0, 1'b0);
    idle_ticks(1, 1'b0, 1'b1);
    idle_ticks(2, 1'b1, 1'b1);
    check("contention_set", {31'b0, contention}, 32'd1);
    idle_ticks(5, 1'b0, 1'b1);
    check("contention_sticky", {31'b0, contention}, 32'd1);

    // Overflow with RX stalled, then none with RX draining
    do_reset();
    idle_ticks(D + 2, 1'b1, 1'b0);
    check("ovf_set", {31'b0, overflow}, 32'd1);
    idle_ticks(2, 1'b0, 1'b0);
    do_reset();
    idle_ticks(D + 2, 1'b1, 1'b1);
    check("ovf_clear", {31'b0, overflow}, 32'd0);
    idle_ticks(3, 1'b0, 1'b1);

    // Reset in the middle of a drive burst
    for (int i = 0; i < 4; i++)
      tick(1'b1, W'(16'h0a0 + i), 1'b0, 1'b1, '0, 1'b0);
    do_reset();
    check("midrst_tx_ready", {31'b0, tx_ready}, 32'd1);
    check("midrst_rx_valid", {31'b0, rx_valid}, 32'd0);
    idle_ticks(2, 1'b0, 1'b1);

    // dut_oe alternates every three cycles while TX stays busy
    for (int i = 0; i < 30; i++)
      tick(1'b1, W'($urandom), ((i / 3) % 2) == 1, 1'b1,
           W'($urandom), 1'b0);
    do_reset();

    // Randomized traffic
    begin
      logic oe_r;
      oe_r = 1'b0;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 5) == 0)
          oe_r = ~oe_r;
        tick($urandom_range(0, 1) == 1, W'($urandom), oe_r,
             $urandom_range(0, 9) < 7, W'($urandom),
             $urandom_range(0, 99) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
